fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding memory request, redirect handling and a
// one-entry skid buffer so a stalled decode never loses an accepted word.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        invalidate,
    input  logic        branch,
    input  logic [31:0] branch_address,
    output logic        fetch_request,
    output logic [31:0] fetch_address,
    input  logic        fetch_ready,
    input  logic [31:0] fetch_data,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    localparam logic [31:0] Align = 32'hFFFF_FFFC;

    logic [31:0] pc_q, pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        redirect_pending_q, redirect_pending_d;
    logic [31:0] redirect_target_q, redirect_target_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] instr_q, instr_d;

    logic handshake;
    logic discard;
    logic accept;
    logic branch_now;

    assign fetch_request = !reset && !buf_valid_q;
    assign fetch_address = pc_q & Align;

    always_comb begin
        handshake  = fetch_request && fetch_ready;
        discard    = redirect_pending_q || branch || (invalidate && !stall);
        accept     = handshake && !discard;
        // A branch may only move pc when no request is waiting on memory.
        branch_now = branch && (handshake || !fetch_request);
    end

    always_comb begin
        pc_d               = pc_q;
        redirect_pending_d = redirect_pending_q;
        redirect_target_d  = redirect_target_q;
        buf_valid_d        = buf_valid_q;
        buf_pc_d           = buf_pc_q;
        buf_instr_d        = buf_instr_q;
        valid_d            = valid_q;
        pc_out_d           = pc_out_q;
        next_pc_d          = next_pc_q;
        instr_d            = instr_q;

        if (branch_now) begin
            pc_d               = branch_address & Align;
            redirect_pending_d = 1'b0;
        end else if (branch) begin
            redirect_pending_d = 1'b1;
            redirect_target_d  = branch_address;
        end else if (handshake && redirect_pending_q) begin
            pc_d               = redirect_target_q & Align;
            redirect_pending_d = 1'b0;
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end

        if (stall) begin
            if (accept) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = pc_q;
                buf_instr_d = fetch_data;
            end
        end else if (invalidate) begin
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
        end else if (buf_valid_q) begin
            valid_d     = 1'b1;
            pc_out_d    = buf_pc_q;
            next_pc_d   = buf_pc_q + 32'd4;
            instr_d     = buf_instr_q;
            buf_valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            pc_out_d  = pc_q;
            next_pc_d = pc_q + 32'd4;
            instr_d   = fetch_data;
        end else begin
            valid_d = 1'b0;
        end

        // Anything buffered behind a branch is on the wrong path.
        if (branch) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q               <= RESET_VECTOR;
            redirect_pending_q <= 1'b0;
            redirect_target_q  <= 32'h0;
            buf_valid_q        <= 1'b0;
            buf_pc_q           <= 32'h0;
            buf_instr_q        <= 32'h0;
            valid_q            <= 1'b0;
            pc_out_q           <= 32'h0;
            next_pc_q          <= 32'h0;
            instr_q            <= 32'h0;
        end else begin
            pc_q               <= pc_d;
            redirect_pending_q <= redirect_pending_d;
            redirect_target_q  <= redirect_target_d;
            buf_valid_q        <= buf_valid_d;
            buf_pc_q           <= buf_pc_d;
            buf_instr_q        <= buf_instr_d;
            valid_q            <= valid_d;
            pc_out_q           <= pc_out_d;
            next_pc_q          <= next_pc_d;
            instr_q            <= instr_d;
        end
    end

    assign valid_out       = valid_q;
    assign pc_out          = pc_out_q;
    assign next_pc_out     = next_pc_q;
    assign instruction_out = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_stage;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        invalidate;
    logic        branch;
    logic [31:0] branch_address;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [31:0] pc_out;
    logic [31:0] next_pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] salt;

    int total = 0;
    int bad = 0;

    fetch_stage #(.RESET_VECTOR(RV)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .invalidate     (invalidate),
        .branch         (branch),
        .branch_address (branch_address),
        .fetch_request  (fetch_request),
        .fetch_address  (fetch_address),
        .fetch_ready    (fetch_ready),
        .fetch_data     (fetch_data),
        .pc_out         (pc_out),
        .next_pc_out    (next_pc_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a, input logic [31:0] s);
        return {a[15:0], a[31:16]} ^ s;
    endfunction

    assign fetch_data = word_of(fetch_address, salt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; invalidate = 1'b0; branch = 1'b0;
        branch_address = 32'h0; fetch_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; invalidate = 1'b0; branch = 1'b1;
        branch_address = 32'h0000_0200; fetch_ready = 1'b1;
        step();
        step();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h exp=0", valid_out); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
        total++; if (next_pc_out !== 32'h0) begin bad++; $display("FAIL reset_next_pc got=%h exp=0", next_pc_out); end
        total++; if (instruction_out !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instruction_out); end
        total++; if (fetch_request !== 1'b0) begin bad++; $display("FAIL reset_req got=%h exp=0", fetch_request); end
        reset = 1'b0; branch = 1'b0; stall = 1'b0;
        #1;
        total++; if (fetch_request !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%h exp=1", fetch_request); end
        total++; if (fetch_address !== RV) begin bad++; $display("FAIL reset_first_addr got=%h exp=%h", fetch_address, RV); end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] p;
            p = RV + 32'(4 * i);
            step();
            total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%h exp=1", i, valid_out); end
            total++; if (pc_out !== p) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, pc_out, p); end
            total++; if (next_pc_out !== p + 32'd4) begin bad++; $display("FAIL stream_next[%0d] got=%h exp=%h", i, next_pc_out, p + 32'd4); end
            total++; if (instruction_out !== word_of(p, salt)) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, instruction_out, word_of(p, salt)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        fetch_ready = 1'b1;
        step();
        stall = 1'b1;
        step();
        total++; if (fetch_request !== 1'b0) begin bad++; $display("FAIL stall_backpressure got=%h exp=0", fetch_request); end
        step();
        step();
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL stall_hold_valid got=%h exp=1", valid_out); end
        total++; if (pc_out !== RV) begin bad++; $display("FAIL stall_hold_pc got=%h exp=%h", pc_out, RV); end
        total++; if (instruction_out !== word_of(RV, salt)) begin bad++; $display("FAIL stall_hold_instr got=%h exp=%h", instruction_out, word_of(RV, salt)); end
        stall = 1'b0;
        step();
        total++; if (pc_out !== RV + 32'd4) begin bad++; $display("FAIL stall_buf_pc got=%h exp=%h", pc_out, RV + 32'd4); end
        total++; if (next_pc_out !== RV + 32'd8) begin bad++; $display("FAIL stall_buf_next got=%h exp=%h", next_pc_out, RV + 32'd8); end
        total++; if (instruction_out !== word_of(RV + 32'd4, salt)) begin bad++; $display("FAIL stall_buf_instr got=%h exp=%h", instruction_out, word_of(RV + 32'd4, salt)); end
        step();
        total++; if (valid_out !== 1'b1 || pc_out !== RV + 32'd8) begin bad++; $display("FAIL stall_after_pc got=%h/%h exp=1/%h", valid_out, pc_out, RV + 32'd8); end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_ready = 1'b1;
        step();
        step();
        fetch_ready = 1'b0; branch = 1'b1; branch_address = 32'h0000_0100;
        step();
        branch = 1'b0;
        total++; if (fetch_request !== 1'b1 || fetch_address !== RV + 32'd8) begin bad++; $display("FAIL redir_hold_addr got=%h/%h exp=1/%h", fetch_request, fetch_address, RV + 32'd8); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL redir_no_valid got=%h exp=0", valid_out); end
        step();
        total++; if (fetch_address !== RV + 32'd8) begin bad++; $display("FAIL redir_hold_addr2 got=%h exp=%h", fetch_address, RV + 32'd8); end
        fetch_ready = 1'b1;
        step();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL redir_dropped got=%h exp=0", valid_out); end
        total++; if (fetch_address !== 32'h0000_0100) begin bad++; $display("FAIL redir_target got=%h exp=100", fetch_address); end
        step();
        total++; if (valid_out !== 1'b1 || pc_out !== 32'h0000_0100) begin bad++; $display("FAIL redir_present got=%h/%h exp=1/100", valid_out, pc_out); end
    endtask

    task automatic test_branch_invalidate();
        do_reset();
        fetch_ready = 1'b1;
        step();
        step();
        step();
        branch = 1'b1; invalidate = 1'b1; branch_address = 32'h0000_0040;
        step();
        branch = 1'b0; invalidate = 1'b0;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL brinv_valid got=%h exp=0", valid_out); end
        total++; if (fetch_address !== 32'h0000_0040) begin bad++; $display("FAIL brinv_addr got=%h exp=40", fetch_address); end
        step();
        total++; if (valid_out !== 1'b1 || pc_out !== 32'h0000_0040) begin bad++; $display("FAIL brinv_present got=%h/%h exp=1/40", valid_out, pc_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        fetch_ready = 1'b1; branch = 1'b1; branch_address = 32'hFFFF_FFFE;
        step();
        branch = 1'b0;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL wrap_discard got=%h exp=0", valid_out); end
        total++; if (fetch_address !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_align got=%h exp=fffffffc", fetch_address); end
        step();
        total++; if (pc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=fffffffc", pc_out); end
        total++; if (next_pc_out !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=0", next_pc_out); end
        total++; if (fetch_address !== 32'h0) begin bad++; $display("FAIL wrap_fetch got=%h exp=0", fetch_address); end
        step();
        total++; if (valid_out !== 1'b1 || pc_out !== 32'h0) begin bad++; $display("FAIL wrap_after got=%h/%h exp=1/0", valid_out, pc_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_ready = 1'b1;
        step();
        step();
        fetch_ready = 1'b0;
        step();
        reset = 1'b1; fetch_ready = 1'b1;
        step();
        total++; if (valid_out !== 1'b0 || pc_out !== 32'h0 || next_pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            bad++; $display("FAIL rstmid_outs got=%h/%h/%h/%h exp=0/0/0/0", valid_out, pc_out, next_pc_out, instruction_out);
        end
        total++; if (fetch_request !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%h exp=0", fetch_request); end
        reset = 1'b0;
        total++; if (fetch_address !== RV) begin bad++; $display("FAIL rstmid_addr got=%h exp=%h", fetch_address, RV); end
        step();
        total++; if (valid_out !== 1'b1 || pc_out !== RV) begin bad++; $display("FAIL rstmid_first got=%h/%h exp=1/%h", valid_out, pc_out, RV); end
        stall = 1'b1;
        step();
        total++; if (fetch_request !== 1'b0) begin bad++; $display("FAIL rstbuf_full got=%h exp=0", fetch_request); end
        reset = 1'b1;
        step();
        total++; if (valid_out !== 1'b0 || pc_out !== 32'h0) begin bad++; $display("FAIL rstbuf_outs got=%h/%h exp=0/0", valid_out, pc_out); end
        reset = 1'b0; stall = 1'b0; fetch_ready = 1'b0;
        step();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rstbuf_stale got=%h exp=0", valid_out); end
        total++; if (fetch_request !== 1'b1 || fetch_address !== RV) begin bad++; $display("FAIL rstbuf_addr got=%h/%h exp=1/%h", fetch_request, fetch_address, RV); end
    endtask

    // Model: pc to fetch, a pending redirect, and a queue of accepted words awaiting decode.
    task automatic test_random();
        logic [31:0] m_pc, m_tgt, m_pco, m_instr;
        logic        m_pend, m_valid, m_req, hs, disc, acc;
        logic [63:0] held[$];
        logic [63:0] w;
        do_reset();
        m_pc = RV; m_tgt = 32'h0; m_pend = 1'b0; m_valid = 1'b0; m_pco = 32'h0; m_instr = 32'h0;
        held.delete();
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 49) == 0);
            stall          = ($urandom_range(0, 9) < 3);
            invalidate     = ($urandom_range(0, 9) == 0);
            branch         = ($urandom_range(0, 9) == 0);
            branch_address = $urandom();
            fetch_ready    = ($urandom_range(0, 9) < 6);
            salt           = $urandom();
            m_req          = !reset && (held.size() == 0);
            #1;
            total++; if (fetch_request !== m_req) begin bad++; $display("FAIL rnd_req[%0d] got=%h exp=%h", c, fetch_request, m_req); end
            if (m_req) begin
                total++; if (fetch_address !== m_pc) begin bad++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", c, fetch_address, m_pc); end
            end
            if (reset) begin
                m_pc = RV; m_pend = 1'b0; held.delete(); m_valid = 1'b0;
            end else begin
                hs   = m_req && fetch_ready;
                disc = m_pend || branch || (invalidate && !stall);
                acc  = hs && !disc;
                w    = {m_pc, word_of(m_pc, salt)};
                if (branch && (hs || !m_req)) begin
                    m_pc = branch_address & ~32'd3; m_pend = 1'b0;
                end else if (branch) begin
                    m_pend = 1'b1; m_tgt = branch_address;
                end else if (hs && m_pend) begin
                    m_pc = m_tgt & ~32'd3; m_pend = 1'b0;
                end else if (acc) begin
                    m_pc = m_pc + 32'd4;
                end
                if (stall) begin
                    if (acc) held.push_back(w);
                end else if (invalidate) begin
                    m_valid = 1'b0; held.delete();
                end else if (held.size() > 0) begin
                    w = held.pop_front();
                    m_valid = 1'b1; m_pco = w[63:32]; m_instr = w[31:0];
                end else if (acc) begin
                    m_valid = 1'b1; m_pco = w[63:32]; m_instr = w[31:0];
                end else begin
                    m_valid = 1'b0;
                end
                if (branch) held.delete();
            end
            step();
            total++; if (valid_out !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%h exp=%h", c, valid_out, m_valid); end
            if (m_valid) begin
                total++; if (pc_out !== m_pco || next_pc_out !== m_pco + 32'd4 || instruction_out !== m_instr) begin
                    bad++; $display("FAIL rnd_word[%0d] got=%h/%h/%h exp=%h/%h/%h", c, pc_out, next_pc_out, instruction_out, m_pco, m_pco + 32'd4, m_instr);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        salt = 32'h1357_9BDF;
        reset = 1'b1; stall = 1'b0; invalidate = 1'b0; branch = 1'b0;
        branch_address = 32'h0; fetch_ready = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_branch_invalidate();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
